// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared constants and types for the 4:1 round-robin
//                arbitrated mux (requester count, select type, pointer
//                reset value).
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] sel_t;

    // Pointer reset value: "last granted" = highest index, so port 0 is
    // first in line after reset.
    localparam sel_t c_ptr_rst = sel_t'(N_REQ - 1);

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick_4
//  Description : Combinational round-robin picker for four requesters.
//                Priority order is ptr+1, ptr+2, ptr+3, ptr (mod 4), where
//                ptr is the index of the last granted requester.
//  Ports       : req [3:0] in  - request vector
//                ptr       in  - last granted index
//                any       out - at least one request present
//                win       out - winning index (valid only when any=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             any,
    output sel_t             win
);

    sel_t w_idx;

    // Walk from lowest to highest priority so the last hit (highest
    // priority) is the one that sticks. The 2-bit add wraps modulo 4,
    // so k=4 lands on ptr itself, the lowest-priority slot.
    always_comb begin
        any   = |req;
        win   = ptr;
        w_idx = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ptr + sel_t'(k);
            if (req[w_idx]) begin
                win = w_idx;
            end
        end
    end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/mux_4_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4_1_rr_arbiter
//  Description : Four requesters share one 4:1 data mux under round-robin
//                arbitration. The winning word is captured in a single
//                registered output slot with a valid/ready handshake.
//  Ports       : clk          in   clock, all state on rising edge
//                rst          in   synchronous active-high reset
//                req[3:0]     in   req[i]=1: requester i holds data on d_i
//                d0..d3[W-1:0] in  requester data words
//                gnt[3:0]     out  one-hot combinational grant
//                out_valid    out  output slot holds a word
//                out_ready    in   consumer accepts the word this cycle
//                out_data     out  captured word
//                out_sel[1:0] out  index of requester that supplied out_data
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_REQ-1:0] gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output sel_t             out_sel
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    sel_t         r_out_sel;
    sel_t         r_ptr;

    logic         w_load_en;
    logic         w_any;
    sel_t         w_win;
    logic [W-1:0] w_data;
    logic         w_take;

    rr_pick_4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .win (w_win)
    );

    // The slot can accept a new word when empty or when its current word
    // leaves this cycle. out_ready on an empty slot has no effect.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_take    = !rst && w_load_en && w_any;

    assign gnt = w_take ? (N_REQ'(1) << w_win) : '0;

    // Select-driven tree: an unselected input, even if X, never reaches
    // w_data because w_win is always a known value.
    assign w_data = w_win[1] ? (w_win[0] ? d3 : d2)
                             : (w_win[0] ? d1 : d0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= c_ptr_rst;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_win;
                r_ptr       <= w_win;
            end else begin
                // Slot drains; data/sel keep their last value.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : mux_4_1_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_4_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_4_1_rr_arbiter
//  Description : Self-checking bench for mux_4_1_rr_arbiter. A small
//                reference model predicts grants; captured words are queued
//                when granted and compared when they appear on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4_1_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   gnt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    sel_t         out_sel;

    mux_4_1_rr_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    // Reference model state
    logic         m_valid;
    int           m_ptr;
    logic [W-1:0] m_data;
    logic [1:0]   m_sel;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [W-1:0] data_of(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // One clock cycle: drive, check grant mid-cycle, advance model, check outputs.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy);
        logic [3:0] eg;
        int         win;
        exp_t       e;
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(negedge clk);
        win = -1;
        for (int k = 1; k <= 4; k++) begin
            if (win < 0 && rq[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
        eg = 4'b0000;
        if (!r && (!m_valid || rdy) && win >= 0) eg[win] = 1'b1;
        chk("gnt", {4'b0, gnt}, {4'b0, eg});
        if (r) begin
            m_valid = 1'b0;
            m_ptr   = 3;
            m_data  = '0;
            m_sel   = 2'd0;
            sb_q.delete();
            sb_q.push_back('{sel: 2'd0, data: '0});
        end else if (!m_valid || rdy) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_ptr   = win;
                m_sel   = 2'(win);
                m_data  = data_of(win);
                sb_q.push_back('{sel: m_sel, data: m_data});
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_sel", {6'b0, out_sel}, {6'b0, e.sel});
            chk("out_data", {4'b0, out_data}, {4'b0, e.data});
        end else if (m_valid) begin
            chk("held_data", {4'b0, out_data}, {4'b0, m_data});
            chk("held_sel", {6'b0, out_sel}, {6'b0, m_sel});
        end
    endtask

    initial begin
        m_valid   = 1'b0;
        m_ptr     = 3;
        m_data    = '0;
        m_sel     = 2'd0;
        rst       = 1'b1;
        req       = 4'h0;
        out_ready = 1'b0;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;

        // Reset with all requesting, then first grant goes to port 0
        cyc(1'b1, 4'hF, 1'b1);
        cyc(1'b1, 4'hF, 1'b1);

        // Round-robin rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF, 1'b1);

        // Stall: load 7 from port 0 (ptr currently 0 -> port 0 is last)
        d0 = 4'h7;
        cyc(1'b0, 4'b0001, 1'b1);
        d2 = 4'h5;
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b1);

        // Sparse / single requests: grants 1,1,3,0
        d1 = 4'h1; d3 = 4'h3; d0 = 4'h9;
        cyc(1'b0, 4'b0010, 1'b1);
        d1 = 4'h2;
        cyc(1'b0, 4'b0010, 1'b1);
        cyc(1'b0, 4'b1001, 1'b1);
        cyc(1'b0, 4'b1001, 1'b1);

        // Idle drains the slot
        cyc(1'b0, 4'b0000, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            d0 = 4'($urandom); d1 = 4'($urandom);
            d2 = 4'($urandom); d3 = 4'($urandom);
            cyc(1'b0, 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, 4'b0000, 1'b1);

        // X isolation
        d3 = 'x;
        d0 = 4'h7;
        cyc(1'b0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b1000, 1'b1);
        d3 = 4'h6;

        // Reset mid-stream with ptr=2 and slot full
        d2 = 4'hE;
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b1, 4'hF, 1'b0);
        cyc(1'b0, 4'hF, 1'b1);
        cyc(1'b0, 4'hF, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mux_4_1_rr_arbiter
`default_nettype wire
